// File: rtl/trivium_ctrl.sv
// trivium_ctrl
//   Sequencing controller for the trivium keystream core behind an 8-bit IO.
//   A 20-byte key/IV stream is collected over a valid/ready port. The core
//   load is then pulsed, and the core runs through its warm-up with the
//   output discarded. After that, keystream bits are packed LSB-first into
//   bytes and presented on a backpressured valid/ready output port.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   abort           synchronous return to LOAD, clears key/IV and buffers
//   cfg_valid/ready config byte handshake, cfg_data carries key then IV bytes
//   out_valid/ready keystream byte handshake, out_data carries the byte
//   in_data         plaintext byte, used only when TRIVIUM_CTRL_XOR_EN is set
//   status          0=LOAD 1=INIT 2=WARM 3=RUN
//   core_rst        load pulse to the core (key/IV captured on that edge)
//   core_en         step enable to the core, one step per high edge
//   core_key/iv     key and IV presented to the core
//   core_ks         keystream bit from the core, valid while core_en is high
//
// Configuration macro
//   TRIVIUM_CTRL_XOR_EN  out_data = holding register ^ in_data (combinational)
module trivium_ctrl #(
  parameter int WARMUP = 1152,
  parameter int NBYTES = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  input  logic [7:0]  in_data,
  output logic [1:0]  status,
  output logic        core_rst,
  output logic        core_en,
  output logic [79:0] core_key,
  output logic [79:0] core_iv,
  input  logic        core_ks
);

  localparam int          KEY_BYTES   = NBYTES / 2;
  localparam logic [4:0]  KEY_BYTES_W = 5'(KEY_BYTES);
  localparam logic [4:0]  LAST_BYTE   = 5'(NBYTES - 1);
  localparam logic [10:0] LAST_WARM   = 11'(WARMUP - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_INIT = 2'd1,
    ST_WARM = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  byte_cnt_q, byte_cnt_d;
  logic [10:0] warm_cnt_q, warm_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  asm_q, asm_d;
  logic [7:0]  hold_q, hold_d;
  logic        out_valid_q, out_valid_d;
  logic        cfg_ready_q, cfg_ready_d;
  logic        core_rst_q, core_rst_d;
  logic        core_en_q, core_en_d;
  logic [79:0] key_q, key_d;
  logic [79:0] iv_q, iv_d;
  logic [7:0]  new_byte;
  logic [3:0]  iv_idx;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    asm_d       = asm_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    key_d       = key_q;
    iv_d        = iv_q;
    // Bits enter at the top and shift down, so after eight bits the first
    // one sits in bit 0.
    new_byte    = {core_ks, asm_q[7:1]};
    // Modulo-16 arithmetic gives the IV byte index for byte counts 10..19.
    iv_idx      = byte_cnt_q[3:0] - 4'(KEY_BYTES);

    if (abort) begin
      state_d     = ST_LOAD;
      byte_cnt_d  = '0;
      warm_cnt_d  = '0;
      bit_cnt_d   = '0;
      asm_d       = '0;
      hold_d      = '0;
      out_valid_d = 1'b0;
      key_d       = '0;
      iv_d        = '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      case (state_q)
        ST_LOAD: begin
          if (cfg_valid && cfg_ready_q) begin
            if (byte_cnt_q < KEY_BYTES_W) begin
              key_d[{byte_cnt_q[3:0], 3'b000} +: 8] = cfg_data;
            end else begin
              iv_d[{iv_idx, 3'b000} +: 8] = cfg_data;
            end
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = '0;
              state_d    = ST_INIT;
            end else begin
              byte_cnt_d = byte_cnt_q + 5'd1;
            end
          end
        end
        ST_INIT: begin
          state_d    = ST_WARM;
          warm_cnt_d = '0;
        end
        ST_WARM: begin
          if (core_en_q) begin
            if (warm_cnt_q == LAST_WARM) begin
              warm_cnt_d = '0;
              state_d    = ST_RUN;
            end else begin
              warm_cnt_d = warm_cnt_q + 11'd1;
            end
          end
        end
        ST_RUN: begin
          if (core_en_q) begin
            asm_d     = new_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            // The enable logic below guarantees that the holding register is
            // free whenever the eighth bit is captured.
            if (bit_cnt_q == 3'd7 && (!out_valid_q || out_ready)) begin
              hold_d      = new_byte;
              out_valid_d = 1'b1;
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end

    cfg_ready_d = (state_d == ST_LOAD);
    core_rst_d  = (state_d == ST_INIT);
    // core_en is registered, so the consumer's out_ready for the coming cycle
    // is unknown here. The core is held whenever the next bit would complete
    // a byte while the holding register is still occupied. This ensures that
    // no step is ever taken without its bit being kept.
    core_en_d   = (state_d == ST_WARM) ||
                  ((state_d == ST_RUN) && !((bit_cnt_d == 3'd7) && out_valid_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      byte_cnt_q  <= '0;
      warm_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      asm_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      cfg_ready_q <= 1'b1;
      core_rst_q  <= 1'b0;
      core_en_q   <= 1'b0;
      key_q       <= '0;
      iv_q        <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      asm_q       <= asm_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      cfg_ready_q <= cfg_ready_d;
      core_rst_q  <= core_rst_d;
      core_en_q   <= core_en_d;
      key_q       <= key_d;
      iv_q        <= iv_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign out_valid = out_valid_q;
  assign status    = state_q;
  assign core_rst  = core_rst_q;
  assign core_en   = core_en_q;
  assign core_key  = key_q;
  assign core_iv   = iv_q;

`ifdef TRIVIUM_CTRL_XOR_EN
  assign out_data = hold_q ^ in_data;
`else
  logic unused_in_data;
  assign unused_in_data = ^in_data;
  assign out_data = hold_q;
`endif

endmodule

// File: tb/tb_trivium_ctrl.sv
// tb_trivium_ctrl
//   Self-checking bench for trivium_ctrl. A stand-in keystream core produces
//   a pseudo-random bit that depends on the loaded key, the loaded IV and the
//   number of steps since load. The reference model predicts every output
//   from event counts:
//     - configuration bytes taken,
//     - edges since the load completed,
//     - keystream bits captured,
//     - bytes delivered.
//   Expected keystream bytes are computed directly from the step index.
module tb_trivium_ctrl;

  localparam int WARMUP = 1152;
  localparam int NBYTES = 20;
  localparam int RUN_T  = WARMUP + 1;

  logic        clk = 1'b0;
  logic        rst, abort, cfg_valid, cfg_ready, out_valid, out_ready;
  logic [7:0]  cfg_data, out_data, in_data;
  logic [1:0]  status;
  logic        core_rst, core_en, core_ks;
  logic [79:0] core_key, core_iv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trivium_ctrl #(.WARMUP(WARMUP), .NBYTES(NBYTES)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_data(in_data), .status(status),
    .core_rst(core_rst), .core_en(core_en),
    .core_key(core_key), .core_iv(core_iv), .core_ks(core_ks)
  );

  // Keystream bit for a given key, IV and step count since load.
  function automatic logic ks_fn(input logic [79:0] k, input logic [79:0] v, input int s);
    logic [31:0] h;
    h = k[31:0] ^ k[63:32] ^ {k[79:64], 16'h0} ^ (v[31:0] * 32'd3) ^ v[63:32] ^
        {16'h0, v[79:64]} ^ (32'(s) * 32'h9E3779B1);
    h = h ^ (h >> 15);
    h = h * 32'h2C1B3C6D;
    h = h ^ (h >> 12);
    h = h * 32'h297A2D39;
    h = h ^ (h >> 15);
    return h[7] ^ h[19] ^ h[31];
  endfunction

  // Keystream byte n after warm-up, first bit in bit 0.
  function automatic logic [7:0] expByte(input logic [79:0] k, input logic [79:0] v, input int n);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ks_fn(k, v, WARMUP + 8 * n + i);
    return b;
  endfunction

  // Stand-in core: captures key/IV on core_rst and counts steps on core_en.
  logic [79:0] c_key = '0;
  logic [79:0] c_iv  = '0;
  int          c_step = 0;
  always @(posedge clk) begin
    if (core_rst) begin
      c_key  <= core_key;
      c_iv   <= core_iv;
      c_step <= 0;
    end else if (core_en) begin
      c_step <= c_step + 1;
    end
  end
  assign core_ks = ks_fn(c_key, c_iv, c_step);

  // Reference model state.
  int          m_t;      // edges since the last config byte, -1 while loading
  int          m_nb;     // config bytes taken in the current load
  logic [79:0] m_key, m_iv;
  int          m_bits;   // keystream bits captured since load
  int          m_deliv;  // bytes handed to the consumer
  bit          chk_en = 1'b0;

  function automatic int expStatus();
    if (m_t < 0) return 0;
    if (m_t == 0) return 1;
    if (m_t <= WARMUP) return 2;
    return 3;
  endfunction

  function automatic bit expFull();
    return (m_bits / 8) > m_deliv;
  endfunction

  function automatic bit expEn();
    int st;
    st = expStatus();
    return (st == 2) || ((st == 3) && !(((m_bits % 8) == 7) && expFull()));
  endfunction

  always @(posedge clk) begin : model
    int st;
    bit full, en;
    st   = expStatus();
    full = expFull();
    en   = expEn();
    if (rst || abort) begin
      m_t = -1; m_nb = 0; m_key = '0; m_iv = '0; m_bits = 0; m_deliv = 0;
    end else if (st == 0) begin
      if (cfg_valid) begin
        if (m_nb < 10) m_key[8 * m_nb +: 8] = cfg_data;
        else m_iv[8 * (m_nb - 10) +: 8] = cfg_data;
        m_nb++;
        if (m_nb == NBYTES) begin
          m_nb = 0;
          m_t  = 0;
        end
      end
    end else begin
      if (st == 3) begin
        if (full && out_ready) m_deliv++;
        if (en) m_bits++;
      end
      m_t++;
    end
  end

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every DUT output against the model on each falling edge.
  always @(negedge clk) begin : compare
    int st;
    logic [7:0] hold, exp_od;
    if (chk_en) begin
      st   = expStatus();
      hold = (m_bits >= 8) ? expByte(m_key, m_iv, m_bits / 8 - 1) : 8'h00;
`ifdef TRIVIUM_CTRL_XOR_EN
      exp_od = hold ^ in_data;
`else
      exp_od = hold;
`endif
      checkOutput("status",    80'(status),    80'(st));
      checkOutput("cfg_ready", 80'(cfg_ready), 80'(st == 0));
      checkOutput("core_rst",  80'(core_rst),  80'(st == 1));
      checkOutput("core_en",   80'(core_en),   80'(expEn()));
      checkOutput("out_valid", 80'(out_valid), 80'(expFull()));
      checkOutput("out_data",  80'(out_data),  80'(exp_od));
      checkOutput("core_key",  core_key, m_key);
      checkOutput("core_iv",   core_iv,  m_iv);
    end
  end

  // Drive one cycle of inputs, then advance to just after the next edge.
  task automatic applyStimulus(input logic r, input logic a, input logic cv,
                               input logic [7:0] cd, input logic ordy);
    rst       = r;
    abort     = a;
    cfg_valid = cv;
    cfg_data  = cd;
    out_ready = ordy;
    in_data   = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  // Stream the first n config bytes (key then IV), with optional random gaps.
  task automatic loadBytes(input logic [79:0] k, input logic [79:0] v, input bit gaps, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) applyStimulus(0, 0, 0, 8'($urandom), 1'($urandom));
      end
      b = (i < 10) ? k[8 * i +: 8] : v[8 * (i - 10) +: 8];
      applyStimulus(0, 0, 1, b, 1'($urandom));
    end
  endtask

  // mode 0: consumer always ready, 1: random, 2: stalled.
  task automatic runCycles(input int n, input int mode);
    logic ordy;
    for (int i = 0; i < n; i++) begin
      ordy = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      applyStimulus(0, 0, 1'($urandom), 8'($urandom), ordy);
    end
  endtask

  initial begin
    logic [79:0] key, iv;
    int first, prev_rise, warm_cnt, rst_cnt;
    logic prev_valid;

    rst = 1'b1; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0; out_ready = 1'b0; in_data = '0;

    // Reset held for two cycles.
    applyStimulus(1, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 8'h00, 0);
    checkOutput("rst_cfg_ready", 80'(cfg_ready), 80'd1);
    checkOutput("rst_out_valid", 80'(out_valid), 80'd0);
    checkOutput("rst_status",    80'(status),    80'd0);
    checkOutput("rst_core_en",   80'(core_en),   80'd0);
    checkOutput("rst_core_rst",  80'(core_rst),  80'd0);
    checkOutput("rst_core_key",  core_key, 80'd0);
    checkOutput("rst_core_iv",   core_iv,  80'd0);
    chk_en = 1'b1;

    // Load order: bytes 0x01..0x14 back to back, then timing of the sequence.
    for (int i = 0; i < 10; i++) begin
      key[8 * i +: 8] = 8'(i + 1);
      iv[8 * i +: 8]  = 8'(i + 11);
    end
    loadBytes(key, iv, 0, NBYTES);
    checkOutput("load_key", core_key, 80'h0A090807060504030201);
    checkOutput("load_iv",  core_iv,  80'h14131211100F0E0D0C0B);
    checkOutput("init_status", 80'(status), 80'd1);
    rst_cnt = core_rst ? 1 : 0;
    warm_cnt = 0; first = -1; prev_rise = -1; prev_valid = 1'b0;
    for (int e = 1; e <= RUN_T + 8 + 8 * 11; e++) begin
      applyStimulus(0, 0, 0, 8'h00, 1);
      if (status == 2'd2) warm_cnt++;
      if (core_rst) rst_cnt++;
      if (out_valid && !prev_valid) begin
        if (first < 0) first = e;
        else checkOutput("byte_gap", 80'(e - prev_rise), 80'd8);
        prev_rise = e;
      end
      prev_valid = out_valid;
    end
    checkOutput("warm_cycles",   80'(warm_cnt), 80'd1152);
    checkOutput("core_rst_len",  80'(rst_cnt),  80'd1);
    checkOutput("first_valid_a", 80'(first),    80'd1161);
    applyStimulus(0, 1, 0, 8'h00, 1);

    // First byte timing with an all-zero key and IV, then backpressure.
    loadBytes(80'd0, 80'd0, 0, NBYTES);
    first = -1;
    for (int e = 1; e <= 1200 && first < 0; e++) begin
      applyStimulus(0, 0, 0, 8'h00, 1);
      if (out_valid) first = e;
    end
    checkOutput("first_valid_b", 80'(first), 80'd1161);
    runCycles(43, 0);
    runCycles(100, 2);
    checkOutput("stall_core_en",   80'(core_en),   80'd0);
    checkOutput("stall_out_valid", 80'(out_valid), 80'd1);
    runCycles(200, 0);
    applyStimulus(0, 1, 0, 8'h00, 1);

    // Abort at warm-up cycle 500 while a config byte is offered.
    key = {16'($urandom), $urandom, $urandom};
    iv  = {16'($urandom), $urandom, $urandom};
    loadBytes(key, iv, 1, NBYTES);
    runCycles(500, 1);
    checkOutput("warm500_status", 80'(status), 80'd2);
    applyStimulus(0, 1, 1, 8'hA5, 1);
    checkOutput("abort_w_status",    80'(status),    80'd0);
    checkOutput("abort_w_key",       core_key,       80'd0);
    checkOutput("abort_w_cfg_ready", 80'(cfg_ready), 80'd1);

    // Reload, then abort during an output handshake.
    loadBytes(key, iv, 1, NBYTES);
    runCycles(RUN_T + 20, 1);
    for (int i = 0; i < 64 && !out_valid; i++) applyStimulus(0, 0, 0, 8'h00, 0);
    checkOutput("wait_valid", 80'(out_valid), 80'd1);
    applyStimulus(0, 1, 0, 8'h00, 1);
    checkOutput("abort_r_status",    80'(status),    80'd0);
    checkOutput("abort_r_out_valid", 80'(out_valid), 80'd0);
    checkOutput("abort_r_key",       core_key,       80'd0);
    checkOutput("abort_r_iv",        core_iv,        80'd0);
    loadBytes(key, iv, 1, NBYTES);
    runCycles(RUN_T + 300, 1);
    applyStimulus(0, 1, 0, 8'h00, 1);

    // Partial load abandoned by abort, then randomized loads and runs.
    loadBytes(key, iv, 1, 7);
    applyStimulus(0, 1, 1, 8'h5A, 1);
    checkOutput("abort_l_key", core_key, 80'd0);
    for (int r = 0; r < 3; r++) begin
      key = {16'($urandom), $urandom, $urandom};
      iv  = {16'($urandom), $urandom, $urandom};
      loadBytes(key, iv, 1, NBYTES);
      runCycles(RUN_T + $urandom_range(100, 600), 1);
      applyStimulus(0, 1, 1'($urandom), 8'($urandom), 1'($urandom));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
